// File: rtl/mam_sram_responder.sv
// mam_sram_responder
//   Memory-side responder for MAM debug accesses. Serves single and burst
//   read/write requests from an internal synchronous word-wide array and
//   always completes the handshake, even for beats outside its window
//   (writes dropped, reads return zero, sticky oob_err set).
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_rw, req_addr               1=write/0=read, byte address of first beat
//   req_burst, req_beats           burst enable and beat count (0 -> 1 beat)
//   write_valid/write_ready        write-beat handshake
//   write_data, write_strb         write beat and byte enables
//   read_valid/read_ready          read-beat handshake
//   read_data                      registered read beat
//   busy                           state != IDLE
//   oob_err                        sticky out-of-window flag
module mam_sram_responder #(
   parameter int unsigned           DATA_WIDTH = 512,
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           MEM_WORDS  = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_burst,
   input  logic [13:0]             req_beats,
   input  logic                    write_valid,
   output logic                    write_ready,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strb,
   output logic                    read_valid,
   input  logic                    read_ready,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    busy,
   output logic                    oob_err
);

   localparam int unsigned NB   = DATA_WIDTH / 8;
   localparam int unsigned OFFS = $clog2(NB);
   localparam int unsigned IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WR       = 2'd1;
   localparam logic [1:0] S_RD_FETCH = 2'd2;
   localparam logic [1:0] S_RD_DATA  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  below_q, below_d;
   logic [13:0]           cnt_q, cnt_d;
   logic                  oob_q, oob_d;
   logic                  rdy_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  in_range;
   logic [IW-1:0]         widx;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   // Index is kept at full address width so beats past the array end stay
   // out of range instead of wrapping; below_q catches addresses under the
   // base whose wrapped difference might otherwise land inside the window.
   assign in_range = !below_q && (idx_q < ADDR_WIDTH'(MEM_WORDS));
   assign widx     = idx_q[IW-1:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      below_d = below_q;
      cnt_d   = cnt_q;
      oob_d   = oob_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && rdy_q) begin
               idx_d   = (req_addr - BASE_ADDR) >> OFFS;
               below_d = (req_addr < BASE_ADDR);
               cnt_d   = (req_burst && req_beats != 14'd0) ? req_beats : 14'd1;
               state_d = req_rw ? S_WR : S_RD_FETCH;
            end
         end
         S_WR: begin
            if (write_valid) begin
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q - 14'd1;
               if (!in_range) oob_d = 1'b1;
               if (cnt_q == 14'd1) state_d = S_IDLE;
            end
         end
         S_RD_FETCH: state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (read_ready) begin
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q - 14'd1;
               if (!in_range) oob_d = 1'b1;
               state_d = (cnt_q > 14'd1) ? S_RD_FETCH : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         below_q <= 1'b0;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
         rdy_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         below_q <= below_d;
         cnt_q   <= cnt_d;
         oob_q   <= oob_d;
         // Registered so req_ready stays low through the cycle after reset.
         rdy_q   <= (state_d == S_IDLE);
         if (state_q == S_RD_FETCH) rdata_q <= in_range ? mem[widx] : '0;
      end
   end

   // Array is not reset; a beat coinciding with reset is not committed.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_WR && write_valid && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (write_strb[b]) mem[widx][8*b +: 8] <= write_data[8*b +: 8];
         end
      end
   end

   assign req_ready   = rdy_q;
   assign write_ready = (state_q == S_WR);
   assign read_valid  = (state_q == S_RD_DATA);
   assign read_data   = rdata_q;
   assign busy        = (state_q != S_IDLE);
   assign oob_err     = oob_q;

endmodule

// File: tb/tb_mam_sram_responder.sv
module tb_mam_sram_responder;

   localparam int unsigned DW   = 512;
   localparam int unsigned AW   = 64;
   localparam logic [63:0] BASE = 64'h1000;
   localparam int unsigned MW   = 16;
   localparam int unsigned NB   = DW / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0, req_ready;
   logic            req_rw = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic            req_burst = 1'b0;
   logic [13:0]     req_beats = '0;
   logic            write_valid = 1'b0, write_ready;
   logic [DW-1:0]   write_data = '0;
   logic [NB-1:0]   write_strb = '0;
   logic            read_valid, read_ready = 1'b0;
   logic [DW-1:0]   read_data;
   logic            busy, oob_err;

   int checks = 0;
   int errors = 0;

   mam_sram_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MEM_WORDS(MW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
      .write_valid(write_valid), .write_ready(write_ready),
      .write_data(write_data), .write_strb(write_strb),
      .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
      .busy(busy), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              rw;
      logic [63:0]       addr;
      logic              burst;
      logic [13:0]       beats;
      int                nb;      // beats actually expected on the bus
      logic [3:0][DW-1:0] data;   // write data or expected read data
      logic [NB-1:0]     strb;
      logic              exp_oob;
   } vec_t;

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      return {NB{b}};
   endfunction

   function automatic logic [63:0] wa(input int w);
      return BASE + 64'(w) * 64'(NB);
   endfunction

   function automatic vec_t mk(input logic rw, input logic [63:0] a, input logic bu,
                               input logic [13:0] be, input int nb,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                               input logic [NB-1:0] st, input logic eo);
      vec_t v;
      v.rw = rw; v.addr = a; v.burst = bu; v.beats = be; v.nb = nb;
      v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
      v.strb = st; v.exp_oob = eo;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic rw, input logic [63:0] a, input logic bu, input logic [13:0] be);
      req_valid = 1'b1; req_rw = rw; req_addr = a; req_burst = bu; req_beats = be;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      string t;
      t = $sformatf("v%0d", id);
      chk({t, "_idle_rdy"}, req_ready, 1);
      issue(v.rw, v.addr, v.burst, v.beats);
      chk({t, "_busy"}, busy, 1);
      chk({t, "_rdy_low"}, req_ready, 0);
      if (v.rw) begin
         for (int k = 0; k < v.nb; k++) begin
            chk({t, "_wr_ready"}, write_ready, 1);
            chk({t, "_no_rv"}, read_valid, 0);
            if (k == 1) begin
               tick();   // idle cycle inside the burst
               chk({t, "_wr_ready_hold"}, write_ready, 1);
            end
            write_valid = 1'b1; write_data = v.data[k]; write_strb = v.strb;
            tick();
            write_valid = 1'b0;
         end
         chk({t, "_wr_done"}, write_ready, 0);
      end else begin
         chk({t, "_fetch_rv"}, read_valid, 0);
         tick();
         for (int k = 0; k < v.nb; k++) begin
            chk({t, "_rv"}, read_valid, 1);
            chk({t, $sformatf("_rdata%0d", k)}, read_data, v.data[k]);
            read_ready = 1'b1;
            tick();
            read_ready = 1'b0;
            if (k < v.nb - 1) begin
               chk({t, "_gap_rv"}, read_valid, 0);
               tick();
            end
         end
         chk({t, "_rd_done"}, read_valid, 0);
      end
      chk({t, "_rdy_back"}, req_ready, 1);
      chk({t, "_busy_off"}, busy, 0);
      chk({t, "_oob"}, oob_err, v.exp_oob);
   endtask

   localparam int NV = 16;
   vec_t vt[NV];
   logic [DW-1:0] mix;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      mix = {{(NB-1){8'hFF}}, 8'h00};
      vt[0]  = mk(1, wa(0),  0, 0, 1, rep(8'hA5), '0, '0, '0, '1, 0);
      vt[1]  = mk(0, wa(0),  0, 0, 1, rep(8'hA5), '0, '0, '0, '0, 0);
      vt[2]  = mk(1, wa(8),  1, 4, 4, DW'(1), DW'(2), DW'(3), DW'(4), '1, 0);
      vt[3]  = mk(0, wa(8),  1, 4, 4, DW'(1), DW'(2), DW'(3), DW'(4), '0, 0);
      vt[4]  = mk(1, wa(8),  0, 0, 1, rep(8'hFF), '0, '0, '0, '1, 0);
      vt[5]  = mk(1, wa(8),  0, 0, 1, rep(8'h00), '0, '0, '0, NB'(1), 0);
      vt[6]  = mk(0, wa(8),  0, 0, 1, mix, '0, '0, '0, '0, 0);
      vt[7]  = mk(1, wa(6),  0, 0, 1, rep(8'h66), '0, '0, '0, '1, 0);
      vt[8]  = mk(1, wa(5),  1, 0, 1, rep(8'h77), '0, '0, '0, '1, 0);
      vt[9]  = mk(0, wa(5),  1, 2, 2, rep(8'h77), rep(8'h66), '0, '0, '0, 0);
      vt[10] = mk(1, wa(15), 0, 0, 1, rep(8'h3C), '0, '0, '0, '1, 0);
      vt[11] = mk(0, wa(15), 1, 2, 2, rep(8'h3C), '0, '0, '0, '0, 1);
      vt[12] = mk(1, BASE - 64'd64, 0, 0, 1, rep(8'h99), '0, '0, '0, '1, 1);
      vt[13] = mk(0, wa(15), 0, 0, 1, rep(8'h3C), '0, '0, '0, '0, 1);
      vt[14] = mk(0, wa(0),  0, 0, 1, rep(8'hA5), '0, '0, '0, '0, 1);
      vt[15] = mk(0, wa(20), 0, 0, 1, '0, '0, '0, '0, '0, 1);

      // Reset state
      rst = 1'b1;
      tick(); tick(); tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_write_ready", write_ready, 0);
      chk("rst_read_valid", read_valid, 0);
      chk("rst_read_data", read_data, '0);
      chk("rst_busy", busy, 0);
      chk("rst_oob", oob_err, 0);
      rst = 1'b0;
      chk("post_rst_rdy_low", req_ready, 0);
      tick();
      chk("post_rst_rdy_high", req_ready, 1);

      for (int i = 0; i < NV; i++) begin
         if (i == 11) begin
            // Backpressure: data holds for 5 stalled cycles on word 8.
            issue(0, wa(8), 0, 0);
            chk("bp_fetch", read_valid, 0);
            tick();
            for (int c = 0; c < 5; c++) begin
               chk("bp_rv_hold", read_valid, 1);
               chk("bp_data_hold", read_data, mix);
               chk("bp_rdy_low", req_ready, 0);
               tick();
            end
            chk("bp_rv_last", read_valid, 1);
            read_ready = 1'b1;
            tick();
            read_ready = 1'b0;
            chk("bp_done_rv", read_valid, 0);
            chk("bp_done_rdy", req_ready, 1);

            // Continuous read_ready: a beat every other cycle.
            read_ready = 1'b1;
            issue(0, wa(5), 1, 2);
            chk("cont_t1_rv", read_valid, 0);
            tick();
            chk("cont_t2_rv", read_valid, 1);
            chk("cont_t2_data", read_data, rep(8'h77));
            tick();
            chk("cont_t3_rv", read_valid, 0);
            tick();
            chk("cont_t4_rv", read_valid, 1);
            chk("cont_t4_data", read_data, rep(8'h66));
            tick();
            chk("cont_t5_rv", read_valid, 0);
            chk("cont_t5_rdy", req_ready, 1);
            read_ready = 1'b0;
         end
         run_vec(vt[i], i);
      end

      // Reset in the middle of an 8-beat write after two committed beats.
      run_vec(mk(1, wa(0), 1, 4, 4, rep(8'h10), rep(8'h11), rep(8'h12), rep(8'h13), '1, 1), 100);
      issue(1, wa(0), 1, 8);
      for (int k = 0; k < 2; k++) begin
         write_valid = 1'b1; write_data = rep(8'hE0 + 8'(k)); write_strb = '1;
         tick();
      end
      rst = 1'b1;
      write_data = rep(8'hE2);
      tick();
      chk("mrst_busy", busy, 0);
      chk("mrst_wr_ready", write_ready, 0);
      chk("mrst_oob_clr", oob_err, 0);
      rst = 1'b0;
      tick();   // write_valid still high while idle: must be ignored
      write_valid = 1'b0;
      chk("mrst_rdy", req_ready, 1);
      chk("mrst_idle", busy, 0);
      run_vec(mk(0, wa(0), 1, 4, 4, rep(8'hE0), rep(8'hE1), rep(8'h12), rep(8'h13), '0, 0), 101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
